// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Function : Run/set controller for a BCD time-of-day counter (1 s tick,
//            hour/minute/second editing, load strobe, display and blink mask)
// Revision : 1.0
// ============================================================================
module clock_set_ctrl #(
  parameter int CLK_DIV   = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_key_mode,
  input  logic        i_key_inc,
  input  logic        i_key_dec,
  input  logic [23:0] i_time,
  output logic        o_tick,
  output logic        o_load,
  output logic [23:0] o_load_time,
  output logic [23:0] o_disp_time,
  output logic [2:0]  o_blink,
  output logic [1:0]  o_mode
);

  localparam int c_presc_w = $clog2(CLK_DIV);
  localparam int c_blink_w = $clog2(BLINK_DIV);
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_DIV - 1);
  localparam logic [c_blink_w-1:0] c_blink_max = c_blink_w'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [23:0]            r_edit;
  logic [c_presc_w-1:0]   r_presc;
  logic [c_blink_w-1:0]   r_bcnt;
  logic                   r_phase;
  logic                   r_tick;
  logic                   r_load;
  logic [23:0]            r_load_time;
  logic [23:0]            r_disp;
  logic [2:0]             r_blink;

  logic                   w_presc_wrap;
  logic                   w_bcnt_wrap;
  logic                   w_phase_nxt;
  logic [2:0]             w_field_mask;
  logic [23:0]            w_edit_nxt;

  // One BCD field step with wrap; anything outside 00..max (incl. non-BCD)
  // snaps to 00 on increment and to max on decrement.
  function automatic logic [7:0] bcd_step(input logic [7:0] val, input logic up,
                                          input logic [3:0] max_t, input logic [3:0] max_u);
    logic [3:0] t;
    logic [3:0] u;
    logic       bad;
    t   = val[7:4];
    u   = val[3:0];
    bad = (t > max_t) || (u > 4'd9) || ((t == max_t) && (u > max_u));
    if (up) begin
      if (bad || ((t == max_t) && (u == max_u))) bcd_step = 8'h00;
      else if (u == 4'd9)                        bcd_step = {t + 4'd1, 4'd0};
      else                                       bcd_step = {t, u + 4'd1};
    end else begin
      if (bad || (val == 8'h00)) bcd_step = {max_t, max_u};
      else if (u == 4'd0)        bcd_step = {t - 4'd1, 4'd9};
      else                       bcd_step = {t, u - 4'd1};
    end
  endfunction

  assign w_presc_wrap = (r_presc == c_presc_max);
  assign w_bcnt_wrap  = (r_bcnt == c_blink_max);
  assign w_phase_nxt  = w_bcnt_wrap ? ~r_phase : r_phase;

  always_comb begin
    w_field_mask = 3'b000;
    case (r_state)
      ST_SET_HOUR: w_field_mask = 3'b100;
      ST_SET_MIN:  w_field_mask = 3'b010;
      ST_SET_SEC:  w_field_mask = 3'b001;
      default:     w_field_mask = 3'b000;
    endcase
  end

  // Simultaneous inc+dec cancels out
  always_comb begin
    w_edit_nxt = r_edit;
    if (i_key_inc ^ i_key_dec) begin
      case (r_state)
        ST_SET_HOUR: w_edit_nxt[23:16] = bcd_step(r_edit[23:16], i_key_inc, 4'd2, 4'd3);
        ST_SET_MIN:  w_edit_nxt[15:8]  = bcd_step(r_edit[15:8],  i_key_inc, 4'd5, 4'd9);
        ST_SET_SEC:  w_edit_nxt[7:0]   = bcd_step(r_edit[7:0],   i_key_inc, 4'd5, 4'd9);
        default:     w_edit_nxt        = r_edit;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_edit      <= '0;
      r_presc     <= '0;
      r_bcnt      <= '0;
      r_phase     <= 1'b0;
      r_tick      <= 1'b0;
      r_load      <= 1'b0;
      r_load_time <= '0;
      r_disp      <= '0;
      r_blink     <= 3'b000;
    end else begin
      r_disp <= (r_state == ST_RUN) ? i_time : r_edit;
      r_load <= 1'b0;
      if (i_key_mode) begin
        // Mode key wins over inc/dec; every transition restarts both counters
        r_state <= state_t'(r_state + 2'd1);
        r_presc <= '0;
        r_tick  <= 1'b0;
        r_bcnt  <= '0;
        r_phase <= 1'b0;
        r_blink <= 3'b000;
        if (r_state == ST_RUN) begin
          r_edit <= i_time;
        end
        if (r_state == ST_SET_SEC) begin
          r_load      <= 1'b1;
          r_load_time <= r_edit;
        end
      end else if (r_state == ST_RUN) begin
        r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
        r_tick  <= w_presc_wrap;
        r_bcnt  <= '0;
        r_phase <= 1'b0;
        r_blink <= 3'b000;
      end else begin
        r_presc <= '0;
        r_tick  <= 1'b0;
        r_bcnt  <= w_bcnt_wrap ? '0 : r_bcnt + 1'b1;
        r_phase <= w_phase_nxt;
        r_blink <= w_field_mask & {3{w_phase_nxt}};
        r_edit  <= w_edit_nxt;
      end
    end
  end

  assign o_tick      = r_tick;
  assign o_load      = r_load;
  assign o_load_time = r_load_time;
  assign o_disp_time = r_disp;
  assign o_blink     = r_blink;
  assign o_mode      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Function : Self-checking bench for clock_set_ctrl with a behavioural model
// Revision : 1.0
// ============================================================================
module tb_clock_set_ctrl;

  localparam int CLK_DIV   = 10;
  localparam int BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_mode = 1'b0;
  logic        key_inc = 1'b0;
  logic        key_dec = 1'b0;
  logic [23:0] tim = '0;
  logic        tick;
  logic        load;
  logic [23:0] load_time;
  logic [23:0] disp_time;
  logic [2:0]  blink;
  logic [1:0]  mode;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: plain integers, decimal field arithmetic
  int          m_state;
  logic [23:0] m_edit;
  logic [23:0] m_load_time;
  logic [23:0] m_disp;
  logic        m_load;
  logic        m_tick;
  logic [2:0]  m_blink;
  int          m_run_k;
  int          m_blink_n;

  clock_set_ctrl #(.CLK_DIV(CLK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .i_clk(clk), .i_reset(rst), .i_key_mode(key_mode), .i_key_inc(key_inc),
    .i_key_dec(key_dec), .i_time(tim), .o_tick(tick), .o_load(load),
    .o_load_time(load_time), .o_disp_time(disp_time), .o_blink(blink), .o_mode(mode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] field_step(input logic [7:0] v, input logic up, input int maxv);
    int val;
    int r;
    val = int'(v[7:4]) * 10 + int'(v[3:0]);
    if (up) r = (val >= maxv) ? 0 : val + 1;
    else    r = (val == 0 || val > maxv) ? maxv : val - 1;
    field_step = {4'(r / 10), 4'(r % 10)};
  endfunction

  function automatic logic [23:0] rand_time();
    int h;
    int mi;
    int s;
    h  = int'($urandom_range(0, 29));
    mi = int'($urandom_range(0, 59));
    s  = int'($urandom_range(0, 59));
    rand_time = {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_edit = '0; m_load_time = '0; m_disp = '0;
    m_load = 1'b0; m_tick = 1'b0; m_blink = 3'b000; m_run_k = 0; m_blink_n = 0;
  endtask

  // Drive one cycle of keys/time, advance the model at the edge, return at edge+1
  task automatic clk_cycle(input logic m, input logic inc, input logic dec, input logic [23:0] t);
    int old;
    logic [2:0] fm;
    key_mode = m; key_inc = inc; key_dec = dec; tim = t;
    @(posedge clk);
    old    = m_state;
    m_disp = (old == 0) ? t : m_edit;
    m_load = (old == 3) && m;
    if (m_load) m_load_time = m_edit;
    if (m) begin
      if (old == 0) m_edit = t;
      m_state = (old + 1) % 4;
    end else if (old != 0 && (inc != dec)) begin
      case (old)
        1:       m_edit[23:16] = field_step(m_edit[23:16], inc, 23);
        2:       m_edit[15:8]  = field_step(m_edit[15:8], inc, 59);
        default: m_edit[7:0]   = field_step(m_edit[7:0], inc, 59);
      endcase
    end
    if (old == 0 && m_state == 0) begin
      m_run_k++;
      m_tick = ((m_run_k % CLK_DIV) == 0);
    end else begin
      m_run_k = 0;
      m_tick  = 1'b0;
    end
    if (m || m_state == 0) m_blink_n = 0;
    else                   m_blink_n++;
    case (m_state)
      1:       fm = 3'b100;
      2:       fm = 3'b010;
      3:       fm = 3'b001;
      default: fm = 3'b000;
    endcase
    m_blink = (((m_blink_n / BLINK_DIV) % 2) == 1) ? fm : 3'b000;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({tick, load, load_time, disp_time, blink, mode} !== 55'd0) begin
        n_errors++;
        $display("FAIL reset_outputs: got %h required 0", {tick, load, load_time, disp_time, blink, mode});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_tick_run();
    int ticks = 0;
    logic exp_t;
    for (int i = 1; i <= 35; i++) begin
      clk_cycle(1'b0, 1'b0, 1'b0, 24'h101010);
      exp_t = ((i % CLK_DIV) == 0);
      n_checks++;
      if (tick !== exp_t) begin
        n_errors++;
        $display("FAIL run_tick cycle %0d: got %b required %b", i, tick, exp_t);
      end
      if (tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != 3 || mode !== 2'd0) begin
      n_errors++;
      $display("FAIL run_tick_count: got %0d ticks mode %0d required 3 ticks mode 0", ticks, mode);
    end
  endtask

  task automatic test_set_edit();
    int first = 0;
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h235958);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h235958);
    n_checks++;
    if (mode !== 2'd1 || disp_time !== 24'h235958 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL enter_set_hour: got mode %0d disp %h tick %b required 1 235958 0", mode, disp_time, tick);
    end
    clk_cycle(1'b0, 1'b1, 1'b0, 24'h235958);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h235958);
    n_checks++;
    if (disp_time !== 24'h005958) begin
      n_errors++; $display("FAIL hour_inc_wrap: got %h required 005958", disp_time);
    end
    clk_cycle(1'b0, 1'b0, 1'b1, 24'h235958);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h235958);
    n_checks++;
    if (disp_time !== 24'h235958 || tick !== 1'b0) begin
      n_errors++; $display("FAIL hour_dec_wrap: got %h tick %b required 235958 0", disp_time, tick);
    end
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h235958);
    clk_cycle(1'b0, 1'b1, 1'b0, 24'h235958);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h235958);
    n_checks++;
    if (mode !== 2'd2 || disp_time !== 24'h230058) begin
      n_errors++; $display("FAIL min_inc_wrap: got mode %0d disp %h required 2 230058", mode, disp_time);
    end
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h235958);
    clk_cycle(1'b0, 1'b0, 1'b1, 24'h235958);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h111111);
    n_checks++;
    if (mode !== 2'd3 || disp_time !== 24'h230057 || load !== 1'b0) begin
      n_errors++; $display("FAIL sec_dec: got mode %0d disp %h load %b required 3 230057 0", mode, disp_time, load);
    end
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h111111);
    n_checks++;
    if (load !== 1'b1 || load_time !== 24'h230057 || mode !== 2'd0) begin
      n_errors++; $display("FAIL load_strobe: got load %b time %h mode %0d required 1 230057 0", load, load_time, mode);
    end
    for (int k = 1; k <= 15 && first == 0; k++) begin
      clk_cycle(1'b0, 1'b0, 1'b0, 24'h111111);
      n_checks++;
      if (load !== 1'b0) begin
        n_errors++; $display("FAIL load_width: got %b required 0 at cycle %0d", load, k);
      end
      if (tick === 1'b1) first = k;
    end
    n_checks++;
    if (first != CLK_DIV) begin
      n_errors++; $display("FAIL tick_after_load: got %0d required %0d", first, CLK_DIV);
    end
  endtask

  task automatic test_blink();
    logic [2:0] exp_b;
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h120000);
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) clk_cycle(1'b0, 1'b0, 1'b0, 24'h120000);
      exp_b = (((n / BLINK_DIV) % 2) == 1) ? 3'b100 : 3'b000;
      n_checks++;
      if (blink !== exp_b) begin
        n_errors++; $display("FAIL blink_hour n=%0d: got %b required %b", n, blink, exp_b);
      end
    end
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h120000);
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) clk_cycle(1'b0, 1'b0, 1'b0, 24'h120000);
      exp_b = (((n / BLINK_DIV) % 2) == 1) ? 3'b010 : 3'b000;
      n_checks++;
      if (blink !== exp_b) begin
        n_errors++; $display("FAIL blink_min n=%0d: got %b required %b", n, blink, exp_b);
      end
    end
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h120000);
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h120000);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h120000);
    n_checks++;
    if (blink !== 3'b000 || mode !== 2'd0) begin
      n_errors++; $display("FAIL blink_run: got blink %b mode %0d required 000 0", blink, mode);
    end
  endtask

  task automatic test_conflicts();
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h081530);
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h081530);
    clk_cycle(1'b0, 1'b1, 1'b1, 24'h081530);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h081530);
    n_checks++;
    if (disp_time !== 24'h081530) begin
      n_errors++; $display("FAIL inc_dec_together: got %h required 081530", disp_time);
    end
    clk_cycle(1'b1, 1'b1, 1'b0, 24'h081530);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h081530);
    n_checks++;
    if (mode !== 2'd3 || disp_time !== 24'h081530) begin
      n_errors++; $display("FAIL mode_with_inc: got mode %0d disp %h required 3 081530", mode, disp_time);
    end
    clk_cycle(1'b0, 1'b1, 1'b0, 24'h081530);
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h081530);
    n_checks++;
    if (load !== 1'b1 || load_time !== 24'h081531) begin
      n_errors++; $display("FAIL conflict_load: got load %b time %h required 1 081531", load, load_time);
    end
  endtask

  task automatic test_carry();
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h095959);
    clk_cycle(1'b0, 1'b1, 1'b0, 24'h095959);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h095959);
    n_checks++;
    if (disp_time !== 24'h105959) begin
      n_errors++; $display("FAIL carry_09: got %h required 105959", disp_time);
    end
    for (int i = 0; i < 10; i++) clk_cycle(1'b0, 1'b1, 1'b0, 24'h095959);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h095959);
    n_checks++;
    if (disp_time !== 24'h205959) begin
      n_errors++; $display("FAIL carry_19: got %h required 205959", disp_time);
    end
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h095959);
    clk_cycle(1'b0, 1'b1, 1'b0, 24'h095959);
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h095959);
    clk_cycle(1'b0, 1'b1, 1'b0, 24'h095959);
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h095959);
    n_checks++;
    if (load !== 1'b1 || load_time !== 24'h200000) begin
      n_errors++; $display("FAIL carry_min_sec: got load %b time %h required 1 200000", load, load_time);
    end
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h275959);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h275959);
    n_checks++;
    if (disp_time !== 24'h275959) begin
      n_errors++; $display("FAIL capture_as_is: got %h required 275959", disp_time);
    end
    clk_cycle(1'b0, 1'b1, 1'b0, 24'h275959);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h275959);
    n_checks++;
    if (disp_time !== 24'h005959) begin
      n_errors++; $display("FAIL bad_hour_inc: got %h required 005959", disp_time);
    end
    for (int i = 0; i < 3; i++) clk_cycle(1'b1, 1'b0, 1'b0, 24'h275959);
    clk_cycle(1'b1, 1'b0, 1'b0, 24'h275959);
    clk_cycle(1'b0, 1'b0, 1'b1, 24'h275959);
    clk_cycle(1'b0, 1'b0, 1'b0, 24'h275959);
    n_checks++;
    if (disp_time !== 24'h235959) begin
      n_errors++; $display("FAIL bad_hour_dec: got %h required 235959", disp_time);
    end
    for (int i = 0; i < 3; i++) clk_cycle(1'b1, 1'b0, 1'b0, 24'h275959);
  endtask

  task automatic test_reset_mid_edit();
    int first = 0;
    for (int i = 0; i < 3; i++) clk_cycle(1'b1, 1'b0, 1'b0, 24'h010203);
    clk_cycle(1'b0, 1'b1, 1'b0, 24'h010203);
    #2;
    rst = 1'b1;
    model_reset();
    key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    #1;
    n_checks++;
    if ({tick, load, load_time, disp_time, blink, mode} !== 55'd0) begin
      n_errors++; $display("FAIL reset_mid_edit: got %h required 0", {tick, load, load_time, disp_time, blink, mode});
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (load !== 1'b0 || mode !== 2'd0) begin
        n_errors++; $display("FAIL reset_hold: got load %b mode %0d required 0 0", load, mode);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 15 && first == 0; k++) begin
      clk_cycle(1'b0, 1'b0, 1'b0, 24'h010203);
      n_checks++;
      if (load !== 1'b0) begin
        n_errors++; $display("FAIL reset_no_load: got %b required 0", load);
      end
      if (tick === 1'b1) first = k;
    end
    n_checks++;
    if (first != CLK_DIV) begin
      n_errors++; $display("FAIL tick_after_reset: got %0d required %0d", first, CLK_DIV);
    end
  endtask

  task automatic test_random();
    logic m;
    logic inc;
    logic dec;
    logic [55:0] got;
    logic [55:0] exp_v;
    for (int i = 0; i < 400; i++) begin
      m   = ($urandom_range(0, 11) == 0);
      inc = ($urandom_range(0, 2) == 0);
      dec = ($urandom_range(0, 2) == 0);
      clk_cycle(m, inc, dec, rand_time());
      got   = {mode, tick, load, load_time, disp_time, blink};
      exp_v = {2'(m_state), m_tick, m_load, m_load_time, m_disp, m_blink};
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL random cycle %0d: got %h required %h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tick_run();
    test_set_edit();
    test_blink();
    test_conflicts();
    test_carry();
    test_reset_mid_edit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
